// File: rtl/ex_stage_mc_if.sv
// Bundle of ID/EX inputs, forwarding sources and EX/MEM outputs for ex_stage_mc.
// EX_OVERFLOW_TRAP_EN adds the EXOverflow output to both modports.
interface ex_stage_mc_if #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
);
    logic                Flush;
    logic                InValid;
    logic                ALUSrc;
    logic [2:0]          ALUControl;
    logic                MemRead;
    logic                MemWrite;
    logic                RegWrite;
    logic [WIDTH-1:0]    DataA;
    logic [WIDTH-1:0]    DataB;
    logic [WIDTH-1:0]    SignExtend;
    logic [REG_BITS-1:0] Rs;
    logic [REG_BITS-1:0] Rt;
    logic [REG_BITS-1:0] Rd;
    logic                MEMRegWrite;
    logic [REG_BITS-1:0] MEMRd;
    logic [WIDTH-1:0]    MEMData;
    logic                WBRegWrite;
    logic [REG_BITS-1:0] WBRd;
    logic [WIDTH-1:0]    WBData;
    logic                ExStall;
    logic                EXValid;
    logic                EXRegWrite;
    logic                EXMemRead;
    logic                EXMemWrite;
    logic [REG_BITS-1:0] EXRd;
    logic [WIDTH-1:0]    EXData;
    logic [WIDTH-1:0]    EXALUData;

`ifdef EX_OVERFLOW_TRAP_EN
    logic                EXOverflow;

    modport master (
        output Flush, InValid, ALUSrc, ALUControl, MemRead, MemWrite, RegWrite,
        output DataA, DataB, SignExtend, Rs, Rt, Rd,
        output MEMRegWrite, MEMRd, MEMData, WBRegWrite, WBRd, WBData,
        input  ExStall, EXValid, EXRegWrite, EXMemRead, EXMemWrite, EXRd, EXData, EXALUData,
        input  EXOverflow
    );

    modport slave (
        input  Flush, InValid, ALUSrc, ALUControl, MemRead, MemWrite, RegWrite,
        input  DataA, DataB, SignExtend, Rs, Rt, Rd,
        input  MEMRegWrite, MEMRd, MEMData, WBRegWrite, WBRd, WBData,
        output ExStall, EXValid, EXRegWrite, EXMemRead, EXMemWrite, EXRd, EXData, EXALUData,
        output EXOverflow
    );
`else
    modport master (
        output Flush, InValid, ALUSrc, ALUControl, MemRead, MemWrite, RegWrite,
        output DataA, DataB, SignExtend, Rs, Rt, Rd,
        output MEMRegWrite, MEMRd, MEMData, WBRegWrite, WBRd, WBData,
        input  ExStall, EXValid, EXRegWrite, EXMemRead, EXMemWrite, EXRd, EXData, EXALUData
    );

    modport slave (
        input  Flush, InValid, ALUSrc, ALUControl, MemRead, MemWrite, RegWrite,
        input  DataA, DataB, SignExtend, Rs, Rt, Rd,
        input  MEMRegWrite, MEMRd, MEMData, WBRegWrite, WBRd, WBData,
        output ExStall, EXValid, EXRegWrite, EXMemRead, EXMemWrite, EXRd, EXData, EXALUData
    );
`endif
endinterface

// File: rtl/ex_stage_mc.sv
// Execute stage with MEM/WB forwarding, EX/MEM register and an iterative shift-add MUL.
// Optional signed-overflow trap on ADD/SUB enabled by defining EX_OVERFLOW_TRAP_EN.
module ex_stage_mc #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5
) (
    input logic           Clk,
    input logic           Rst,
    ex_stage_mc_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] D_ZERO   = {WIDTH{1'b0}};
    localparam logic [REG_BITS-1:0] R_ZERO = {REG_BITS{1'b0}};

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [WIDTH-1:0]    cap_b_q, cap_b_d;
    logic [REG_BITS-1:0] cap_rd_q, cap_rd_d;
    logic                cap_rw_q, cap_rw_d;
    logic                cap_mr_q, cap_mr_d;
    logic                cap_mw_q, cap_mw_d;

    logic                ex_valid_q, ex_valid_d;
    logic                ex_rw_q, ex_rw_d;
    logic                ex_mr_q, ex_mr_d;
    logic                ex_mw_q, ex_mw_d;
    logic [REG_BITS-1:0] ex_rd_q, ex_rd_d;
    logic [WIDTH-1:0]    ex_data_q, ex_data_d;
    logic [WIDTH-1:0]    ex_alu_q, ex_alu_d;
`ifdef EX_OVERFLOW_TRAP_EN
    logic                ex_ovf_q, ex_ovf_d;
`endif

    logic [WIDTH-1:0]    fwd_a_s, fwd_b_s, op_b_s;
    logic [WIDTH-1:0]    sum_s, diff_s, alu_res_s, product_s;
    logic                trap_s, is_mul_s, issue_s, stall_s;

    // MEM stage wins over WB; register 0 never forwards.
    function automatic logic [WIDTH-1:0] fwd_sel(
        input logic [REG_BITS-1:0] src,
        input logic [WIDTH-1:0]    rf_val,
        input logic                mem_rw,
        input logic [REG_BITS-1:0] mem_rd,
        input logic [WIDTH-1:0]    mem_val,
        input logic                wb_rw,
        input logic [REG_BITS-1:0] wb_rd,
        input logic [WIDTH-1:0]    wb_val
    );
        logic [WIDTH-1:0] res;
        if (mem_rw && (mem_rd != R_ZERO) && (mem_rd == src)) begin
            res = mem_val;
        end else if (wb_rw && (wb_rd != R_ZERO) && (wb_rd == src)) begin
            res = wb_val;
        end else begin
            res = rf_val;
        end
        return res;
    endfunction

    // Operand forwarding and ALUSrc selection.
    always_comb begin
        fwd_a_s = fwd_sel(bus.Rs, bus.DataA, bus.MEMRegWrite, bus.MEMRd, bus.MEMData,
                          bus.WBRegWrite, bus.WBRd, bus.WBData);
        fwd_b_s = fwd_sel(bus.Rt, bus.DataB, bus.MEMRegWrite, bus.MEMRd, bus.MEMData,
                          bus.WBRegWrite, bus.WBRd, bus.WBData);
        if (bus.ALUSrc) begin
            op_b_s = bus.SignExtend;
        end else begin
            op_b_s = fwd_b_s;
        end
    end

    // Single-cycle ALU, overflow detection and MUL issue decode.
    always_comb begin
        sum_s     = fwd_a_s + op_b_s;
        diff_s    = fwd_a_s - op_b_s;
        alu_res_s = D_ZERO;
        case (bus.ALUControl)
            OP_AND:  alu_res_s = fwd_a_s & op_b_s;
            OP_OR:   alu_res_s = fwd_a_s | op_b_s;
            OP_ADD:  alu_res_s = sum_s;
            OP_SUB:  alu_res_s = diff_s;
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(fwd_a_s) < $signed(op_b_s))};
            OP_NOR:  alu_res_s = ~(fwd_a_s | op_b_s);
            OP_XOR:  alu_res_s = fwd_a_s ^ op_b_s;
            default: alu_res_s = D_ZERO;
        endcase
`ifdef EX_OVERFLOW_TRAP_EN
        trap_s = ((bus.ALUControl == OP_ADD) && (fwd_a_s[WIDTH-1] == op_b_s[WIDTH-1])
                                              && (sum_s[WIDTH-1] != fwd_a_s[WIDTH-1]))
              || ((bus.ALUControl == OP_SUB) && (fwd_a_s[WIDTH-1] != op_b_s[WIDTH-1])
                                              && (diff_s[WIDTH-1] != fwd_a_s[WIDTH-1]));
`else
        trap_s = 1'b0;
`endif
        is_mul_s  = (bus.ALUControl == OP_MUL);
        issue_s   = bus.InValid && !bus.Flush && is_mul_s;
        product_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        if (Rst) begin
            stall_s = 1'b0;
        end else if (state_q == IDLE) begin
            stall_s = issue_s;
        end else begin
            stall_s = (cnt_q != CNT_LAST);
        end
    end

    // Next-state logic for the FSM, multiplier datapath and EX/MEM register.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cap_b_d    = cap_b_q;
        cap_rd_d   = cap_rd_q;
        cap_rw_d   = cap_rw_q;
        cap_mr_d   = cap_mr_q;
        cap_mw_d   = cap_mw_q;
        ex_valid_d = 1'b0;
        ex_rw_d    = 1'b0;
        ex_mr_d    = 1'b0;
        ex_mw_d    = 1'b0;
        ex_rd_d    = R_ZERO;
        ex_data_d  = D_ZERO;
        ex_alu_d   = D_ZERO;
`ifdef EX_OVERFLOW_TRAP_EN
        ex_ovf_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.InValid || bus.Flush) begin
                    state_d = IDLE;
                end else if (is_mul_s) begin
                    // Capture everything now so later forwarding changes cannot leak in.
                    state_d  = BUSY;
                    cnt_d    = CNT_ZERO;
                    acc_d    = D_ZERO;
                    mcand_d  = fwd_a_s;
                    mplier_d = op_b_s;
                    cap_b_d  = fwd_b_s;
                    cap_rd_d = bus.Rd;
                    cap_rw_d = bus.RegWrite;
                    cap_mr_d = bus.MemRead;
                    cap_mw_d = bus.MemWrite;
                end else begin
                    ex_valid_d = 1'b1;
                    ex_rw_d    = bus.RegWrite && !trap_s;
                    ex_mr_d    = bus.MemRead;
                    ex_mw_d    = bus.MemWrite && !trap_s;
                    ex_rd_d    = bus.Rd;
                    ex_data_d  = fwd_b_s;
                    ex_alu_d   = alu_res_s;
`ifdef EX_OVERFLOW_TRAP_EN
                    ex_ovf_d   = trap_s;
`endif
                end
            end
            BUSY: begin
                if (bus.Flush) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    acc_d    = product_s;
                    mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                    if (cnt_q == CNT_LAST) begin
                        state_d    = IDLE;
                        cnt_d      = CNT_ZERO;
                        ex_valid_d = 1'b1;
                        ex_rw_d    = cap_rw_q;
                        ex_mr_d    = cap_mr_q;
                        ex_mw_d    = cap_mw_q;
                        ex_rd_d    = cap_rd_q;
                        ex_data_d  = cap_b_q;
                        ex_alu_d   = product_s;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, multiplier and EX/MEM registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_ZERO;
            acc_q      <= D_ZERO;
            mcand_q    <= D_ZERO;
            mplier_q   <= D_ZERO;
            cap_b_q    <= D_ZERO;
            cap_rd_q   <= R_ZERO;
            cap_rw_q   <= 1'b0;
            cap_mr_q   <= 1'b0;
            cap_mw_q   <= 1'b0;
            ex_valid_q <= 1'b0;
            ex_rw_q    <= 1'b0;
            ex_mr_q    <= 1'b0;
            ex_mw_q    <= 1'b0;
            ex_rd_q    <= R_ZERO;
            ex_data_q  <= D_ZERO;
            ex_alu_q   <= D_ZERO;
`ifdef EX_OVERFLOW_TRAP_EN
            ex_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cap_b_q    <= cap_b_d;
            cap_rd_q   <= cap_rd_d;
            cap_rw_q   <= cap_rw_d;
            cap_mr_q   <= cap_mr_d;
            cap_mw_q   <= cap_mw_d;
            ex_valid_q <= ex_valid_d;
            ex_rw_q    <= ex_rw_d;
            ex_mr_q    <= ex_mr_d;
            ex_mw_q    <= ex_mw_d;
            ex_rd_q    <= ex_rd_d;
            ex_data_q  <= ex_data_d;
            ex_alu_q   <= ex_alu_d;
`ifdef EX_OVERFLOW_TRAP_EN
            ex_ovf_q   <= ex_ovf_d;
`endif
        end
    end

    assign bus.ExStall    = stall_s;
    assign bus.EXValid    = ex_valid_q;
    assign bus.EXRegWrite = ex_rw_q;
    assign bus.EXMemRead  = ex_mr_q;
    assign bus.EXMemWrite = ex_mw_q;
    assign bus.EXRd       = ex_rd_q;
    assign bus.EXData     = ex_data_q;
    assign bus.EXALUData  = ex_alu_q;
`ifdef EX_OVERFLOW_TRAP_EN
    assign bus.EXOverflow = ex_ovf_q;
`endif
endmodule

// File: tb/tb_ex_stage_mc.sv
// Bench for ex_stage_mc: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_ex_stage_mc;
    localparam int W  = 32;
    localparam int RB = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_stage_mc_if #(.WIDTH(W), .REG_BITS(RB)) bus ();
    ex_stage_mc #(.WIDTH(W), .REG_BITS(RB)) dut (.Clk(clk), .Rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Model state: busy_left = number of BUSY edges still to come (0 = idle).
    int          busy_left = 0;
    logic [31:0] m_prod, m_fwdb;
    logic [4:0]  m_rd;
    logic        m_rw, m_mr, m_mw;
    logic        e_valid, e_rw, e_mr, e_mw, e_ovf;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_alu;
    logic        last_stall;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd_ref(input logic [4:0] src, input logic [31:0] rf);
        if (bus.MEMRegWrite && bus.MEMRd != 5'd0 && bus.MEMRd == src) return bus.MEMData;
        if (bus.WBRegWrite && bus.WBRd != 5'd0 && bus.WBRd == src) return bus.WBData;
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: return a + b;
            3'b110: return a - b;
            3'b111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b100: return ~(a | b);
            3'b101: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ovf_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint r;
        if (op == 3'b010) r = longint'($signed(a)) + longint'($signed(b));
        else if (op == 3'b110) r = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic logic exp_stall();
        if (rst) return 1'b0;
        if (busy_left > 0) return busy_left > 1;
        return bus.InValid && !bus.Flush && bus.ALUControl == 3'b011;
    endfunction

    task automatic model_edge();
        logic [31:0] a, fb, b;
        logic [63:0] full;
        logic        ov;
        e_valid = 1'b0; e_rw = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_ovf = 1'b0;
        e_rd = 5'd0; e_data = 32'd0; e_alu = 32'd0;
        if (rst) begin
            busy_left = 0;
        end else if (busy_left > 0) begin
            if (bus.Flush) busy_left = 0;
            else if (busy_left == 1) begin
                e_valid = 1'b1; e_rw = m_rw; e_mr = m_mr; e_mw = m_mw;
                e_rd = m_rd; e_data = m_fwdb; e_alu = m_prod;
                busy_left = 0;
            end else busy_left--;
        end else if (bus.InValid && !bus.Flush) begin
            a  = fwd_ref(bus.Rs, bus.DataA);
            fb = fwd_ref(bus.Rt, bus.DataB);
            b  = bus.ALUSrc ? bus.SignExtend : fb;
            if (bus.ALUControl == 3'b011) begin
                full = {32'd0, a} * {32'd0, b};
                m_prod = full[31:0]; m_fwdb = fb; m_rd = bus.Rd;
                m_rw = bus.RegWrite; m_mr = bus.MemRead; m_mw = bus.MemWrite;
                busy_left = W;
            end else begin
                ov = 1'b0;
`ifdef EX_OVERFLOW_TRAP_EN
                ov = ovf_ref(bus.ALUControl, a, b);
`endif
                e_valid = 1'b1; e_ovf = ov;
                e_rw = bus.RegWrite && !ov; e_mr = bus.MemRead; e_mw = bus.MemWrite && !ov;
                e_rd = bus.Rd; e_data = fb; e_alu = alu_ref(bus.ALUControl, a, b);
            end
        end
    endtask

    // One clock: check the combinational stall mid-cycle, then every registered output after the edge.
    task automatic cyc();
        @(negedge clk);
        last_stall = bus.ExStall;
        chk("ExStall", last_stall, exp_stall());
        model_edge();
        @(posedge clk);
        #1;
        chk("EXValid", bus.EXValid, e_valid);
        chk("EXRegWrite", bus.EXRegWrite, e_rw);
        chk("EXMemRead", bus.EXMemRead, e_mr);
        chk("EXMemWrite", bus.EXMemWrite, e_mw);
`ifdef EX_OVERFLOW_TRAP_EN
        chk("EXOverflow", bus.EXOverflow, e_ovf);
`endif
        if (e_valid) begin
            chk("EXRd", bus.EXRd, e_rd);
            chk("EXData", bus.EXData, e_data);
            chk("EXALUData", bus.EXALUData, e_alu);
        end
    endtask

    task automatic clear_inputs();
        bus.Flush = 1'b0; bus.InValid = 1'b0; bus.ALUSrc = 1'b0; bus.ALUControl = 3'b000;
        bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.RegWrite = 1'b0;
        bus.DataA = 32'd0; bus.DataB = 32'd0; bus.SignExtend = 32'd0;
        bus.Rs = 5'd0; bus.Rt = 5'd0; bus.Rd = 5'd0;
        bus.MEMRegWrite = 1'b0; bus.MEMRd = 5'd0; bus.MEMData = 32'd0;
        bus.WBRegWrite = 1'b0; bus.WBRd = 5'd0; bus.WBData = 32'd0;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        clear_inputs();
        bus.InValid = 1'b1; bus.ALUControl = op; bus.RegWrite = 1'b1;
        bus.Rs = 5'd1; bus.Rt = 5'd2; bus.Rd = 5'd9;
        bus.DataA = a; bus.DataB = b;
    endtask

    function automatic logic [31:0] rand_data();
        logic [31:0] t;
        case ($urandom_range(0, 5))
            0: t = 32'h7FFF_FFFF;
            1: t = 32'h8000_0000;
            2: t = 32'hFFFF_FFFF;
            3: t = $urandom_range(0, 15);
            default: t = $urandom;
        endcase
        return t;
    endfunction

    task automatic rand_inputs();
        logic [2:0] ops [8];
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b100, 3'b101, 3'b010};
        rst = ($urandom_range(0, 299) == 0);
        bus.Flush = ($urandom_range(0, 24) == 0);
        bus.InValid = ($urandom_range(0, 7) != 0);
        bus.ALUControl = ($urandom_range(0, 11) == 0) ? 3'b011 : ops[$urandom_range(0, 7)];
        bus.ALUSrc = $urandom_range(0, 1);
        bus.MemRead = $urandom_range(0, 1); bus.MemWrite = $urandom_range(0, 1);
        bus.RegWrite = $urandom_range(0, 1);
        bus.DataA = rand_data(); bus.DataB = rand_data(); bus.SignExtend = rand_data();
        bus.Rs = $urandom_range(0, 3); bus.Rt = $urandom_range(0, 3); bus.Rd = $urandom_range(0, 31);
        bus.MEMRegWrite = $urandom_range(0, 1); bus.MEMRd = $urandom_range(0, 3); bus.MEMData = rand_data();
        bus.WBRegWrite = $urandom_range(0, 1); bus.WBRd = $urandom_range(0, 3); bus.WBData = rand_data();
    endtask

    task automatic run_mul(input string nm, input logic [31:0] expv, input bit disturb);
        int stalls = 0;
        int n = 0;
        do begin
            cyc();
            if (last_stall) stalls++;
            n++;
            if (disturb) begin
                bus.DataA = $urandom; bus.DataB = $urandom;
                bus.MEMRegWrite = 1'b1; bus.MEMRd = 5'd1; bus.MEMData = $urandom;
            end
        end while (last_stall && n < 40);
        chk({nm, "_stall_cycles"}, stalls, 32);
        chk({nm, "_valid"}, bus.EXValid, 1'b1);
        chk({nm, "_result"}, bus.EXALUData, expv);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        cyc();
        cyc();
        chk("rst_valid", bus.EXValid, 1'b0);
        chk("rst_alu", bus.EXALUData, 32'd0);
        chk("rst_data", bus.EXData, 32'd0);
        chk("rst_rd", bus.EXRd, 5'd0);
        rst = 1'b0;

        // MEM beats WB beats register file
        set_op(3'b010, 32'h33, 32'h1);
        bus.Rs = 5'd3; bus.Rt = 5'd5;
        bus.MEMRegWrite = 1'b1; bus.MEMRd = 5'd3; bus.MEMData = 32'h11;
        bus.WBRegWrite = 1'b1; bus.WBRd = 5'd3; bus.WBData = 32'h22;
        cyc();
        chk("fwd_prio_lit", bus.EXALUData, 32'h12);

        // Register 0 never forwards
        set_op(3'b010, 32'h0, 32'h0);
        bus.Rs = 5'd0; bus.ALUSrc = 1'b1; bus.SignExtend = 32'h7;
        bus.MEMRegWrite = 1'b1; bus.MEMRd = 5'd0; bus.MEMData = 32'h55;
        cyc();
        chk("zero_reg_lit", bus.EXALUData, 32'h7);

        set_op(3'b011, 32'h0001_0003, 32'h0000_0005);
        run_mul("mul_lit", 32'h0005_000F, 1'b1);
        chk("mul_storedata_lit", bus.EXData, 32'h5);

        // Back-to-back MUL issues straight from IDLE
        set_op(3'b011, 32'd6, 32'd7);
        run_mul("mul_b2b", 32'd42, 1'b0);

        // Flush at cnt=10
        set_op(3'b011, 32'd3, 32'd4);
        cyc();
        for (int i = 0; i < 10; i++) cyc();
        bus.Flush = 1'b1;
        cyc();
        chk("flush_stall_same_cycle", last_stall, 1'b1);
        chk("flush_bubble", bus.EXValid, 1'b0);
        set_op(3'b010, 32'd2, 32'd3);
        cyc();
        chk("flush_stall_after", last_stall, 1'b0);
        chk("flush_add_lit", bus.EXALUData, 32'd5);

        // Reset in the middle of BUSY
        set_op(3'b011, 32'd9, 32'd9);
        cyc();
        for (int i = 0; i < 5; i++) cyc();
        rst = 1'b1;
        cyc();
        chk("rst_busy_stall", last_stall, 1'b0);
        chk("rst_busy_valid", bus.EXValid, 1'b0);
        chk("rst_busy_alu", bus.EXALUData, 32'd0);
        rst = 1'b0;

        set_op(3'b010, 32'h7FFF_FFFF, 32'h1);
        cyc();
        chk("ovf_add_alu", bus.EXALUData, 32'h8000_0000);
`ifdef EX_OVERFLOW_TRAP_EN
        chk("ovf_flag_lit", bus.EXOverflow, 1'b1);
        chk("ovf_regwrite_lit", bus.EXRegWrite, 1'b0);
`else
        chk("wrap_regwrite_lit", bus.EXRegWrite, 1'b1);
`endif

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised successor to the single-cycle execute stage of the 5-stage pipeline.
- Keeps the MEM/WB operand forwarding and the EX/MEM pipeline register.
- Adds a multi-cycle iterative multiply, with a stall handshake to ID and a synchronous flush.
- Sits between ID/EX and MEMStage; drives the forwarding sources consumed by later stages.

Parameters:
- WIDTH, 32, datapath width in bits (≥4).
- REG_BITS, 5, register-index width; index 0 is the hardwired zero register.

Ports:
- Clk  in  1  pipeline clock, rising-edge active.
- Rst  in  1  synchronous, active-high reset.
- Flush  in  1  squash the current EX instruction (branch/exception).
- InValid  in  1  ID/EX holds a real instruction.
- ALUSrc  in  1  select SignExtend as ALU operand B.
- ALUControl  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 100 NOR, 101 XOR, 011 MUL (multi-cycle, low WIDTH bits).
- MemRead, MemWrite, RegWrite  in  1 each  control bits passed through to EX/MEM.
- DataA, DataB, SignExtend  in  WIDTH each  register-file operands and immediate.
- Rs, Rt, Rd  in  REG_BITS each  source and destination indices.
- MEMRegWrite  in  1;  MEMRd  in  REG_BITS;  MEMData  in  WIDTH  — forwarding source, previous instruction.
- WBRegWrite  in  1;  WBRd  in  REG_BITS;  WBData  in  WIDTH  — forwarding source, second-previous instruction.
- ExStall  out  1  combinational; ID/EX must hold its contents while high.
- EXValid, EXRegWrite, EXMemRead, EXMemWrite  out  1 each  registered.
- EXRd  out  REG_BITS  registered.
- EXData  out  WIDTH  registered forwarded B operand (store data).
- EXALUData  out  WIDTH  registered ALU result or address.

Behaviour:
- Reset:
  - When Rst is high at a rising edge, all outputs clear to 0, state goes to IDLE, and the iteration counter clears.
  - ExStall is forced to 0 while Rst is high.
  - Rst overrides Flush and any in-progress MUL.
- Forwarding (combinational, per operand, A from Rs, B from Rt):
  - MEMRegWrite && MEMRd!=0 && MEMRd==src: use MEMData.
  - Else WBRegWrite && WBRd!=0 && WBRd==src: use WBData.
  - Else use DataA/DataB.
  - MEM has priority when both match.
  - Operand B = ALUSrc ? SignExtend : forwarded B. EXData always carries forwarded B.
- Arithmetic:
  - All single-cycle results are WIDTH bits; ADD/SUB wrap modulo 2^WIDTH.
  - SLT yields 1 or 0 zero-extended.
  - MUL yields the low WIDTH bits of the unsigned product; the result is identical for signed operands.
- FSM states: IDLE, BUSY.
- IDLE, single-cycle op (InValid, not MUL, Flush low): at the edge, the EX/MEM register loads the ALU result; EXValid=1; control bits copied; EXRd=Rd. Latency 1 cycle; ExStall=0.
- IDLE, InValid=0 or Flush=1: at the edge, a bubble is loaded (EXValid, EXRegWrite, EXMemRead, EXMemWrite = 0; data fields don't-care, implementation holds 0).
- IDLE, MUL issue (InValid, ALUControl=011, Flush low):
  - ExStall=1 combinationally.
  - At the edge: capture forwarded A and B (after ALUSrc mux), Rd and control bits; clear the accumulator; cnt=0; go to BUSY; load a bubble.
- BUSY:
  - Each edge performs one shift-add iteration and increments cnt.
  - ExStall=1 while cnt!=WIDTH-1.
  - When cnt==WIDTH-1: ExStall=0. At that edge the final product is written to EXALUData with EXValid=1 and the captured controls; state goes to IDLE. ID advances at the same edge.
  - Every other BUSY edge loads a bubble.
  - Total EX occupancy is WIDTH+1 cycles; ExStall is high for WIDTH cycles.
  - Captured operands are immune to later changes of the forwarding inputs or DataA/DataB.
- Flush in BUSY: aborts the MUL; the edge loads a bubble; state goes to IDLE; ExStall drops the cycle after.
- Back-to-back: a MUL presented the cycle after a MUL completes issues normally from IDLE.

Optional Feature:
- Macro EX_OVERFLOW_TRAP_EN.
- When defined:
  - Adds output port EXOverflow (1 bit, reset 0).
  - Set for signed overflow on ADD/SUB of a valid, unflushed instruction; 0 for all other ops.
  - When set, EXRegWrite and EXMemWrite are forced 0 (result is not committed).
- When undefined: the port is absent, overflow wraps silently, and control bits pass unchanged.

Test Plan:
- Forwarding priority: Rs=3, MEMRd=3 with MEMData=0x11, WBRd=3 with WBData=0x22, DataA=0x33, DataB=1, ADD -> EXALUData=0x12.
- Zero register: MEMRd=0, MEMRegWrite=1, Rs=0, DataA=0 -> no forward; EXALUData equals operand B.
- MUL, WIDTH=32: A=0x0001_0003, B=0x0000_0005 -> ExStall high exactly 32 cycles; bubbles during BUSY; then EXValid=1, EXALUData=0x0005_000F.
- Operand capture: during that MUL, change MEMData and DataA each cycle -> result still 0x0005_000F.
- Flush mid-MUL at cnt=10 -> bubble output, ExStall=0 next cycle; the following ADD 2+3 gives 5.
- Rst high during BUSY -> all outputs 0, ExStall=0 the same cycle; with EX_OVERFLOW_TRAP_EN, ADD 0x7FFF_FFFF+1 -> EXOverflow=1, EXRegWrite=0.
